alu_cmd_issuer: RTL and testbench

//  Upstream command stage for the 4-bit ALU. Buffers operation commands in a small FIFO,

---
 rtl/alu_defs.sv | 24 ++
 rtl/alu_cmd_fifo.sv | 69 ++++++
 rtl/alu_cmd_issuer.sv | 156 +++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the ALU command issuer: ALU select codes,
// issuer FSM encoding and default datapath sizes.
package alu_defs;

    localparam int WIDTH_DEF = 4;
    localparam int SEL_W_DEF = 3;
    localparam int DEPTH_DEF = 4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_INC = 3'b110;
    localparam logic [2:0] ALU_DEC = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Write acceptance is a registered "space" flag
// derived from the next count, so it is low during reset and the cycle after.
module alu_cmd_fifo #(
    parameter int DW    = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DW-1:0]            wr_data,
    input  logic                     pop,
    output logic [DW-1:0]            rd_data,
    output logic                     space,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          space_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign space   = space_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push & space_q & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            space_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            space_q <= (count_d != CW'(DEPTH));
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command stage in front of the combinational ALU: queues commands, drives
// registered ALU operands, captures results and returns them over valid/ready.
module alu_cmd_issuer
    import alu_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output state_t           dbg_state
);

    // Both ports are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid never waits on ready, and ready
    // never depends on valid. A held response stays stable until taken.
    localparam int ENT_W = SEL_W + 2 * WIDTH + 1;

    logic [ENT_W-1:0]       fifo_wdata, fifo_rdata;
    logic                   fifo_empty, fifo_space;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [SEL_W-1:0]       head_sel;
    logic [WIDTH-1:0]       head_a, head_b;
    logic                   head_chain;

    state_t state_q, state_d;
    logic   issue, capture, release_res;

    logic [WIDTH-1:0] alu_a_q, alu_b_q, acc_q, res_data_q;
    logic [SEL_W-1:0] alu_sel_q;
    logic             res_valid_q, res_carry_q, res_zero_q;

    assign fifo_wdata = {cmd_sel, cmd_a, cmd_b, cmd_chain};
    assign {head_sel, head_a, head_b, head_chain} = fifo_rdata;

    alu_cmd_fifo #(
        .DW    (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (cmd_valid),
        .wr_data (fifo_wdata),
        .pop     (issue),
        .rd_data (fifo_rdata),
        .space   (fifo_space),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (res_ready) state_d = fifo_empty ? ST_IDLE : ST_EXEC;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_comb begin
        issue       = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state_q)
            ST_IDLE: issue = ~fifo_empty;
            ST_EXEC: capture = 1'b1;
            ST_RESP: begin
                release_res = res_ready;
                issue       = res_ready & ~fifo_empty;
            end
            default: ;
        endcase
        if (flush) begin
            issue       = 1'b0;
            capture     = 1'b0;
            release_res = 1'b0;
        end
    end

    // Chained commands read acc at issue time; acc already holds the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else if (flush) begin
            acc_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            if (issue) begin
                alu_a_q   <= head_chain ? acc_q : head_a;
                alu_b_q   <= head_b;
                alu_sel_q <= head_sel;
            end
            if (capture) begin
                res_data_q  <= alu_out;
                res_carry_q <= alu_carry & (alu_sel_q == SEL_W'(ALU_ADD));
                res_zero_q  <= alu_zero;
                acc_q       <= alu_out;
                res_valid_q <= 1'b1;
            end else if (release_res) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign cmd_ready = fifo_space;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_zero  = res_zero_q;
    assign acc       = acc_q;
    assign busy      = (state_q != ST_IDLE) | (fifo_count != '0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a stand-in 4-bit ALU on the alu_* ports, directed
// scenarios plus randomized traffic scored against an in-order result model.
module tb_alu_cmd_issuer;
    import alu_defs::*;

    localparam int WIDTH = 4;
    localparam int SEL_W = 3;
    localparam int DEPTH = 4;
    localparam int RW    = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [SEL_W-1:0] cmd_sel = '0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic             cmd_chain = 1'b0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_carry, alu_zero;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data, acc;
    logic             res_carry, res_zero, busy;
    state_t           dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 0;
    int model_acc = 0;
    logic [RW-1:0] exp_q[$];
    logic          hold_q = 1'b0;
    logic [RW-1:0] held_val = '0;

    alu_cmd_issuer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_zero(res_zero), .acc(acc),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Clock / reset-independent clock generation
    always #5 clk = ~clk;

    // Stand-in ALU; carry is deliberately 1 for non-ADD ops (undefined there).
    logic [WIDTH:0] alu_sum;
    always_comb begin
        alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = 1'b1;
        case (alu_sel)
            3'd0: begin alu_out = alu_sum[WIDTH-1:0]; alu_carry = alu_sum[WIDTH]; end
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = ~alu_a;
            3'd6: alu_out = alu_a + 4'd1;
            default: alu_out = alu_a - 4'd1;
        endcase
    end
    assign alu_zero = (alu_out == '0);

    // Reference: {carry, zero, data} from plain integer arithmetic
    function automatic logic [RW-1:0] ref_result(input int sel, input int a, input int b);
        int r;
        int c;
        c = 0;
        case (sel)
            0: begin r = a + b; c = (r > 15) ? 1 : 0; end
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: r = a + 1;
            default: r = a - 1;
        endcase
        r = r & 15;
        return {c[0], (r == 0), r[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Driver: offer one command for up to max_cycles; model it on acceptance.
    task automatic try_push(input int sel, input int a, input int b, input int chain,
                            input int max_cycles, output bit ok);
        logic [RW-1:0] r;
        cmd_sel   = 3'(sel);
        cmd_a     = 4'(a);
        cmd_b     = 4'(b);
        cmd_chain = 1'(chain);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                r = ref_result(sel, (chain != 0) ? model_acc : a, b);
                model_acc = int'(r[WIDTH-1:0]);
                exp_q.push_back(r);
            end
            step(1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic push_cmd(input string tag, input int sel, input int a, input int b,
                            input int chain);
        bit ok;
        try_push(sel, a, b, chain, 40, ok);
        check(tag, 32'(ok), 1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            step(1);
            n++;
        end
        check(tag, 32'(exp_q.size()), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: res_ready = 1'b0;
            1: res_ready = 1'b1;
            default: res_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard: responses in order, and held responses must not change.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (hold_q) begin
                check("hold_valid", 32'(res_valid), 1);
                check("hold_data", 32'({res_carry, res_zero, res_data}), 32'(held_val));
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) check("unexpected_res", 32'(res_valid), 0);
                else check("res", 32'({res_carry, res_zero, res_data}), 32'(exp_q.pop_front()));
            end
            hold_q   = res_valid && !res_ready;
            held_val = {res_carry, res_zero, res_data};
        end else begin
            hold_q = 1'b0;
        end
    end

    initial begin
        bit ok;
        int n_acc;

        // Reset state
        step(3);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_acc", 32'(acc), 0);
        rst_n = 1'b1;
        check("rel_ready_lo", 32'(cmd_ready), 0);
        step(1);
        check("rel_ready_hi", 32'(cmd_ready), 1);

        // ADD overflow with latency
        ready_mode = 1;
        push_cmd("push_add", 0, 9, 8, 0);
        check("lat_t1", 32'(res_valid), 0);
        step(1);
        check("lat_t2", 32'(res_valid), 0);
        step(1);
        check("lat_t3", 32'(res_valid), 1);
        check("add_data", 32'(res_data), 32'h1);
        check("add_carry", 32'(res_carry), 1);
        check("add_zero", 32'(res_zero), 0);
        wait_drain("drain_add");

        // Carry mask on SUB
        push_cmd("push_sub", 1, 1, 5, 0);
        step(2);
        check("sub_valid", 32'(res_valid), 1);
        check("sub_data", 32'(res_data), 32'hc);
        check("sub_carry", 32'(res_carry), 0);
        wait_drain("drain_sub");

        // Chain INC on INC
        push_cmd("push_inc", 6, 14, 0, 0);
        push_cmd("push_chain", 6, 0, 0, 1);
        wait_drain("drain_chain");
        check("chain_acc", 32'(acc), 0);

        // Reset while executing
        push_cmd("push_rst", 0, 3, 4, 0);
        step(1);
        check("rst_in_exec", 32'(dbg_state), 32'(ST_EXEC));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_acc = 0;
        check("mrst_res_valid", 32'(res_valid), 0);
        check("mrst_cmd_ready", 32'(cmd_ready), 0);
        check("mrst_alu", 32'({alu_sel, alu_a, alu_b}), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_rel_lo", 32'(cmd_ready), 0);
        step(1);
        check("mrst_rel_hi", 32'(cmd_ready), 1);

        // Backpressure until full, then drain in order
        ready_mode = 0;
        n_acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            try_push($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), 0, 3, ok);
            if (ok) n_acc++;
        end
        check("full_accepts", 32'(n_acc), 32'(DEPTH + 1));
        check("full_ready", 32'(cmd_ready), 0);
        check("stall_valid", 32'(res_valid), 1);
        check("stall_head", 32'({res_carry, res_zero, res_data}), 32'(exp_q[0]));
        step(3);
        check("stall_head2", 32'({res_carry, res_zero, res_data}), 32'(exp_q[0]));
        ready_mode = 1;
        wait_drain("drain_full");

        // Flush with queued commands and a held response
        ready_mode = 0;
        for (int i = 0; i < 4; i++)
            push_cmd("push_fl", $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), 0);
        check("fl_pre_valid", 32'(res_valid), 1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        exp_q.delete();
        model_acc = 0;
        check("fl_valid", 32'(res_valid), 0);
        check("fl_busy", 32'(busy), 0);
        check("fl_acc", 32'(acc), 0);
        ready_mode = 1;
        step(10);
        check("fl_quiet", 32'(res_valid), 0);

        // Randomized traffic with random backpressure and chaining
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            push_cmd("push_rand", $urandom_range(0, 7), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 4));
        end
        ready_mode = 1;
        wait_drain("drain_rand");
        check("rand_acc", 32'(acc), 32'(model_acc));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
